// File: rtl/wci_req_seq.sv
// rtl/wci_req_seq.sv - WCI request sequencer: dequeues FIFO entries, runs one target access
// with an ack timeout and returns one WCI response per request.
module wci_req_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        wciS0_Clk,
  input  logic        wciS0_Rst,
  input  logic [59:0] req_data,
  input  logic        req_empty,
  output logic        req_deq,
  output logic        cfg_req,
  output logic        ctl_req,
  output logic        tgt_we,
  output logic [19:0] tgt_addr,
  output logic [3:0]  tgt_be,
  output logic [31:0] tgt_wdata,
  input  logic        cfg_ack,
  input  logic        ctl_ack,
  input  logic [31:0] cfg_rdata,
  input  logic [31:0] ctl_rdata,
  output logic [1:0]  wciS0_SResp,
  output logic [31:0] wciS0_SData,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  localparam logic [2:0] CMD_WR    = 3'b001;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        space_q;
  logic [7:0]  cnt;
  logic [1:0]  resp_q, resp_nxt;
  logic [31:0] sdata_q, sdata_nxt;
  logic        cmd_ok;
  logic        sel_ack;
  logic [31:0] sel_rdata;

  assign cmd_ok    = (req_data[59:57] == CMD_WR) || (req_data[59:57] == CMD_RD);
  assign sel_ack   = space_q ? cfg_ack : ctl_ack;
  assign sel_rdata = space_q ? cfg_rdata : ctl_rdata;

  always_ff @(posedge wciS0_Clk) begin
    if (wciS0_Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    resp_nxt    = resp_q;
    sdata_nxt   = sdata_q;
    req_deq     = 1'b0;
    cfg_req     = 1'b0;
    ctl_req     = 1'b0;
    wciS0_SResp = RESP_NULL;
    wciS0_SData = '0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Gated by reset so an entry is never popped while the block is being cleared.
        if (!req_empty && !wciS0_Rst) begin
          req_deq = 1'b1;
          if (cmd_ok) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_RESP;
            resp_nxt  = RESP_ERR;
            sdata_nxt = '0;
          end
        end
      end
      S_WAIT: begin
        cfg_req = space_q;
        ctl_req = !space_q;
        // The ack is checked first so an ack on the last timeout cycle still completes.
        if (sel_ack) begin
          state_nxt = S_RESP;
          resp_nxt  = RESP_DVA;
          sdata_nxt = tgt_we ? 32'd0 : sel_rdata;
        end else if (cnt == TO_LAST) begin
          state_nxt = S_RESP;
          resp_nxt  = RESP_ERR;
          sdata_nxt = '0;
        end
      end
      S_RESP: begin
        wciS0_SResp = resp_q;
        wciS0_SData = sdata_q;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wciS0_Clk) begin
    if (wciS0_Rst) begin
      space_q   <= 1'b0;
      tgt_we    <= 1'b0;
      tgt_addr  <= '0;
      tgt_be    <= '0;
      tgt_wdata <= '0;
      cnt       <= '0;
      resp_q    <= RESP_NULL;
      sdata_q   <= '0;
      err_cnt   <= '0;
    end else begin
      resp_q  <= resp_nxt;
      sdata_q <= sdata_nxt;
      if (req_deq) begin
        space_q   <= req_data[56];
        tgt_be    <= req_data[55:52];
        tgt_addr  <= req_data[51:32];
        tgt_wdata <= req_data[31:0];
        tgt_we    <= (req_data[59:57] == CMD_WR);
        cnt       <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (state == S_RESP && resp_q == RESP_ERR && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
